// File: rtl/stream_mux_n.sv
// N-channel valid/ready packet multiplexer with fixed or round-robin arbitration.
// A channel stays granted until its last beat is accepted; the output beat is registered.
module stream_mux_n #(
  parameter int CHANNELS = 4,
  parameter int DATA_W   = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [SEL_W-1:0]           sel,
  input  logic                       mode,
  input  logic [CHANNELS*DATA_W-1:0] in_data,
  input  logic [CHANNELS-1:0]        in_valid,
  input  logic [CHANNELS-1:0]        in_last,
  output logic [CHANNELS-1:0]        in_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic [SEL_W-1:0]           out_chan,
  output logic                       busy
);

  localparam int PAD = 1 << SEL_W;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   grant_q, grant_d;
  logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic               out_valid_q, out_valid_d;
  logic [SEL_W-1:0]   out_chan_q, out_chan_d;

  logic [PAD-1:0]     valid_pad;
  logic [PAD-1:0]     last_pad;
  logic [DATA_W-1:0]  data_arr [PAD];
  logic               load_en;
  logic               sel_ok;
  logic               rr_found;
  logic [SEL_W-1:0]   rr_pick;

  // Widen per-channel vectors to the full index range so any SEL_W index is in bounds.
  assign valid_pad = PAD'(in_valid);
  assign last_pad  = PAD'(in_last);

  for (genvar k = 0; k < PAD; k++) begin : g_pad
    if (k < CHANNELS) begin : g_real
      assign data_arr[k] = in_data[k*DATA_W +: DATA_W];
    end else begin : g_fill
      assign data_arr[k] = '0;
    end
  end

  assign load_en = !out_valid_q || out_ready;
  assign sel_ok  = (int'(sel) < CHANNELS);

  // First valid channel after the last served one, wrapping around.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      if (!rr_found && valid_pad[(int'(rr_ptr_q) + i) % CHANNELS]) begin
        rr_found = 1'b1;
        rr_pick  = SEL_W'((int'(rr_ptr_q) + i) % CHANNELS);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    out_chan_d  = out_chan_q;
    in_ready    = '0;

    case (state_q)
      IDLE: begin
        if (load_en) begin
          out_valid_d = 1'b0;
        end
        if (!mode) begin
          if (sel_ok && valid_pad[sel]) begin
            grant_d = sel;
            state_d = LOCKED;
          end
        end else if (rr_found) begin
          grant_d = rr_pick;
          state_d = LOCKED;
        end
      end

      LOCKED: begin
        in_ready = CHANNELS'(load_en) << grant_q;
        if (load_en) begin
          if (valid_pad[grant_q]) begin
            out_data_d  = data_arr[grant_q];
            out_last_d  = last_pad[grant_q];
            out_chan_d  = grant_q;
            out_valid_d = 1'b1;
            // Leaving on the last beat gives exactly one IDLE cycle before the next grant.
            if (last_pad[grant_q]) begin
              rr_ptr_d = grant_q;
              state_d  = IDLE;
            end
          end else begin
            out_valid_d = 1'b0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= SEL_W'(CHANNELS - 1);
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;
  assign busy      = (state_q == LOCKED);

endmodule

// File: tb/tb_stream_mux_n.sv
// Scoreboard bench for stream_mux_n: per-channel packet sources, expected beats queued
// in the order the arbitration should serve them, compared as they leave the output.
module tb_stream_mux_n;

  localparam int CH    = 4;
  localparam int DW    = 8;
  localparam int SW    = 2;
  localparam int DEPTH = 32;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [SW-1:0] chan;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [SW-1:0]    sel;
  logic             mode;
  logic [CH*DW-1:0] in_data;
  logic [CH-1:0]    in_valid;
  logic [CH-1:0]    in_last;
  logic [CH-1:0]    in_ready;
  logic [DW-1:0]    out_data;
  logic             out_valid;
  logic             out_last;
  logic             out_ready;
  logic [SW-1:0]    out_chan;
  logic             busy;

  logic [1:0]       sel3;
  logic             mode3;
  logic [3*DW-1:0]  in_data3;
  logic [2:0]       in_valid3;
  logic [2:0]       in_last3;
  logic [2:0]       in_ready3;
  logic [DW-1:0]    out_data3;
  logic             out_valid3;
  logic             out_last3;
  logic             out_ready3;
  logic [1:0]       out_chan3;
  logic             busy3;

  beat_t src_mem [CH][DEPTH];
  int    rd_ptr [CH];
  int    wr_ptr [CH];
  exp_t  exp_q [$];

  int    checks = 0;
  int    errors = 0;
  bit    sb_en = 1'b1;

  logic          samp_busy;
  logic          samp_ovalid;
  logic [DW-1:0] samp_odata;
  logic [CH-1:0] samp_ready;

  always #5 clk = ~clk;

  stream_mux_n #(.CHANNELS(CH), .DATA_W(DW)) u_dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .mode(mode),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .out_chan(out_chan), .busy(busy)
  );

  stream_mux_n #(.CHANNELS(3), .DATA_W(DW)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .sel(sel3), .mode(mode3),
    .in_data(in_data3), .in_valid(in_valid3), .in_last(in_last3), .in_ready(in_ready3),
    .out_data(out_data3), .out_valid(out_valid3), .out_last(out_last3),
    .out_ready(out_ready3), .out_chan(out_chan3), .busy(busy3)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < CH; k++) begin
      if (rd_ptr[k] < wr_ptr[k]) begin
        in_valid[k]          = 1'b1;
        in_data[k*DW +: DW]  = src_mem[k][rd_ptr[k]].data;
        in_last[k]           = src_mem[k][rd_ptr[k]].last;
      end else begin
        in_valid[k]          = 1'b0;
        in_data[k*DW +: DW]  = '0;
        in_last[k]           = 1'b0;
      end
    end
  endtask

  // Queue an n-beat packet on channel ch; optionally expect it at the output in call order.
  task automatic applyStimulus(input int ch, input int n, input logic [DW-1:0] base, input bit push);
    beat_t b;
    exp_t  e;
    for (int i = 0; i < n; i++) begin
      b.data = base + DW'(i);
      b.last = (i == n - 1);
      src_mem[ch][wr_ptr[ch]] = b;
      wr_ptr[ch]++;
      if (push) begin
        e.chan = SW'(ch);
        e.data = b.data;
        e.last = b.last;
        exp_q.push_back(e);
      end
    end
    drive_inputs();
  endtask

  // Sample one cycle at the falling edge, then advance sources past the next rising edge.
  task automatic cycle();
    exp_t          e;
    logic [CH-1:0] acc;
    @(negedge clk);
    acc         = in_valid & in_ready;
    samp_busy   = busy;
    samp_ovalid = out_valid;
    samp_odata  = out_data;
    samp_ready  = in_ready;
    if (out_valid && out_ready && sb_en) begin
      if (exp_q.size() == 0) begin
        checkOutput("sb_extra_beat", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("sb_chan", 32'(out_chan), 32'(e.chan));
        checkOutput("sb_data", 32'(out_data), 32'(e.data));
        checkOutput("sb_last", 32'(out_last), 32'(e.last));
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < CH; k++) begin
      if (acc[k]) rd_ptr[k]++;
    end
    drive_inputs();
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (exp_q.size() != 0 || busy || out_valid); i++) cycle();
    repeat (2) cycle();
    checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    sel        = '0;
    mode       = 1'b0;
    in_data    = '0;
    in_valid   = '0;
    in_last    = '0;
    out_ready  = 1'b1;
    sel3       = '0;
    mode3      = 1'b0;
    in_data3   = '0;
    in_valid3  = '0;
    in_last3   = '0;
    out_ready3 = 1'b1;
    for (int k = 0; k < CH; k++) begin
      rd_ptr[k] = 0;
      wr_ptr[k] = 0;
    end

    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data",  32'(out_data),  32'd0);
    checkOutput("rst_out_last",  32'(out_last),  32'd0);
    checkOutput("rst_out_chan",  32'(out_chan),  32'd0);
    checkOutput("rst_busy",      32'(busy),      32'd0);
    checkOutput("rst_in_ready",  32'(in_ready),  32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle();
    cycle();

    $display("[TB] fixed select, 3-beat packet on ch2");
    mode = 1'b0;
    sel  = 2'd2;
    applyStimulus(2, 3, 8'hA0, 1'b1);
    for (int c = 0; c < 6; c++) begin
      cycle();
      checkOutput($sformatf("t1_busy_c%0d", c), 32'(samp_busy), 32'(c >= 1 && c <= 3));
      checkOutput($sformatf("t1_valid_c%0d", c), 32'(samp_ovalid), 32'(c >= 2 && c <= 4));
    end
    drain();

    $display("[TB] sel change during a locked packet");
    sel = 2'd2;
    applyStimulus(2, 4, 8'hB0, 1'b1);
    applyStimulus(1, 2, 8'hC0, 1'b1);
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (c == 1) sel = 2'd1;
      if (c >= 1 && c <= 4) begin
        checkOutput($sformatf("t2_rdy1_c%0d", c), 32'(samp_ready[1]), 32'd0);
        checkOutput($sformatf("t2_rdy2_c%0d", c), 32'(samp_ready[2]), 32'd1);
      end
      if (c == 5) checkOutput("t2_idle_gap", 32'(samp_busy), 32'd0);
      if (c == 6) begin
        checkOutput("t2_ch1_busy", 32'(samp_busy), 32'd1);
        checkOutput("t2_ch1_rdy", 32'(samp_ready[1]), 32'd1);
      end
    end
    drain();

    $display("[TB] round-robin over four busy channels");
    reset_pulse();
    mode = 1'b1;
    applyStimulus(0, 2, 8'h10, 1'b1);
    applyStimulus(1, 2, 8'h20, 1'b1);
    applyStimulus(2, 2, 8'h30, 1'b1);
    applyStimulus(3, 2, 8'h40, 1'b1);
    applyStimulus(0, 2, 8'h18, 1'b1);
    for (int c = 0; c < 16; c++) begin
      cycle();
      checkOutput($sformatf("t3_busy_c%0d", c), 32'(samp_busy), 32'((c % 3) != 0));
    end
    drain();

    $display("[TB] output backpressure mid-packet");
    mode = 1'b0;
    sel  = 2'd3;
    applyStimulus(3, 5, 8'hD0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      cycle();
      if (c >= 4 && c <= 6) begin
        checkOutput($sformatf("t4_hold_data_c%0d", c), 32'(samp_odata), 32'hD2);
        checkOutput($sformatf("t4_hold_valid_c%0d", c), 32'(samp_ovalid), 32'd1);
        checkOutput($sformatf("t4_hold_rdy_c%0d", c), 32'(samp_ready[3]), 32'd0);
      end
      if (c == 3) out_ready = 1'b0;
      if (c == 6) out_ready = 1'b1;
    end
    drain();

    $display("[TB] out-of-range select on the 3-channel instance");
    sel3      = 2'd3;
    mode3     = 1'b0;
    in_data3  = 24'($urandom);
    in_valid3 = 3'b111;
    for (int c = 0; c < 4; c++) begin
      cycle();
      checkOutput($sformatf("t5_valid_c%0d", c), 32'(out_valid3), 32'd0);
      checkOutput($sformatf("t5_rdy_c%0d", c), 32'(in_ready3), 32'd0);
      checkOutput($sformatf("t5_busy_c%0d", c), 32'(busy3), 32'd0);
    end
    in_valid3 = '0;

    $display("[TB] reset in the middle of a packet");
    mode  = 1'b0;
    sel   = 2'd0;
    sb_en = 1'b0;
    applyStimulus(0, 5, 8'hE0, 1'b0);
    repeat (3) cycle();
    checkOutput("t6_pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_rst_busy", 32'(busy), 32'd0);
    checkOutput("t6_rst_rdy", 32'(in_ready), 32'd0);
    rd_ptr[0] = wr_ptr[0];
    drive_inputs();
    sb_en = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    mode = 1'b1;
    applyStimulus(0, 2, 8'h50, 1'b1);
    applyStimulus(2, 2, 8'h70, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_mux_n.md
Name: stream_mux_n

Overview:
- Parametrised N-channel packet multiplexer for the stereo stage datapath. Successor to the fixed 2:1 and 3:1 combinational selectors.
- Merges CHANNELS valid/ready pixel streams onto one output stream.
- Switches channel only at packet boundaries, marked by the last flag. Never splits a packet.
- Supports fixed (select-driven) and round-robin arbitration. Output is registered for timing closure between stages.

Parameters:
- CHANNELS, 4, number of input streams (2..16).
- DATA_W, 8, data bits per beat.
- SEL_W, $clog2(CHANNELS), width of the select and channel-index signals. Derived; do not override.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sel  in  SEL_W  requested channel in fixed mode. Sampled only in IDLE.
- mode  in  1  0 = fixed select, 1 = round-robin. Sampled only in IDLE.
- in_data  in  CHANNELS*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- in_valid  in  CHANNELS  per-channel beat valid.
- in_last  in  CHANNELS  per-channel end-of-packet flag.
- in_ready  out  CHANNELS  per-channel accept.
- out_data  out  DATA_W  registered output beat.
- out_valid  out  1  output beat valid.
- out_last  out  1  output end-of-packet flag.
- out_ready  in  1  downstream accept.
- out_chan  out  SEL_W  source channel of the current out beat.
- busy  out  1  high while a packet is locked (state LOCKED).

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_last=0, out_chan=0, busy=0, in_ready=0.
  - state=IDLE, grant=0, rr_ptr=CHANNELS-1.
- Transfer rule: a beat moves on any edge where valid && ready. Applies to inputs and output alike.
- FSM IDLE:
  - Fixed mode: if sel<CHANNELS and in_valid[sel]=1, register grant=sel and go to LOCKED.
  - Fixed mode with sel>=CHANNELS: no grant, all in_ready=0, stay IDLE.
  - Round-robin mode: grant the first k with in_valid[k]=1, searching rr_ptr+1, rr_ptr+2, ... with wrap modulo CHANNELS. Go to LOCKED. Stay IDLE if no channel is valid.
  - in_ready=0 for all channels in IDLE.
- FSM LOCKED:
  - in_ready[grant] = load_en, where load_en = !out_valid || out_ready. All other in_ready=0.
  - On in_valid[grant] && load_en: out_data/out_last are loaded from the granted channel, out_chan=grant, out_valid=1.
  - On load_en with no input beat: out_valid=0.
  - Accepted beat with in_last[grant]=1: set rr_ptr=grant and go to IDLE on the same edge.
  - sel and mode changes while LOCKED are ignored until IDLE.
- Latency: in_valid rises in IDLE at cycle 0, grant at edge 1, first beat accepted at edge 2, out_valid high in cycle 2.
- Throughput: 1 beat/cycle within a packet while out_ready=1.
- Packet switch overhead: exactly one IDLE cycle between packets.
- Backpressure: while out_valid=1 and out_ready=0, out_data/out_last/out_chan are held stable and in_ready[grant]=0.
- Last beat drain: after the last beat enters the out register, it drains normally while the FSM sits in IDLE. The next grant may be made, but no new beat loads until load_en.
- Single-beat packet (in_last=1 on first beat): LOCKED lasts one accepting cycle.
- Reset mid-packet: all state cleared. Any in-flight output beat is discarded (out_valid=0 immediately).
- busy = (state==LOCKED).

Test Plan:
- CHANNELS=4, mode=0, sel=2, ch2 sends a 3-beat packet A0,A1,A2 (last on A2), out_ready=1 -> out_data A0,A1,A2 in cycles 2,3,4; out_chan=2; out_last only with A2; busy high for cycles 1-3.
- sel switches 2->1 after the first beat of a 4-beat ch2 packet -> all 4 beats come from ch2; ch1 is granted after one IDLE cycle; in_ready[1]=0 throughout the ch2 packet.
- mode=1, all 4 channels continuously sending 2-beat packets -> out_chan sequence 0,1,2,3,0; one IDLE cycle between packets.
- out_ready held low for 3 cycles mid-packet -> out_data held stable; in_ready[grant]=0 for those 3 cycles; no beat lost or duplicated after release.
- CHANNELS=3, mode=0, sel=3, all in_valid=1 -> out_valid stays 0, in_ready=3'b000, busy=0.
- rst_n asserted during beat 2 of a 5-beat packet -> out_valid, busy and in_ready drop within the same cycle. After release, mode=1 grants ch0 first.
